inst_fetch: RTL and testbench

Instruction fetch unit: the initiator that drives the byte-addressed instruction memory. It holds the PC, presents it as the memory read address, and captures the combinationally returned 32-bit little-endian instruction into a small fetch queue. It hands instructions to decode over a valid/ready handshake and flushes on branch/jump redirects. It sits between the instruction memory and the decode stage.

---
 rtl/inst_fetch_pkg.sv | 31 +++
 rtl/inst_fetch_if.sv | 33 +++
 rtl/inst_fetch_fetch_queue.sv | 69 ++++++
 rtl/inst_fetch.sv | 93 +++++++++
 tb/tb_inst_fetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg
//   Shared types and constants for the instruction fetch slice.
//   - InstAddrBus / InstBus : 32-bit byte address and instruction word types
//   - DEFAULT_RESET_PC      : PC the fetch unit starts from after reset
//   - NOP_INST              : canonical no-op encoding (add x0, x0, x0)
//   - fetch_entry_t         : one fetch-queue entry, instruction plus its address
//   - beyond_mem()          : true when a 4-byte fetch at pc would run past memory
package inst_fetch_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  localparam InstAddrBus DEFAULT_RESET_PC = 32'h0000_0000;
  localparam InstBus     NOP_INST         = 32'h0000_0033;

  typedef struct packed {
    InstBus     inst;
    InstAddrBus pc;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // The last byte of the word is pc + 3. Doing the sum in 33 bits keeps a
  // PC near the top of the address space from wrapping back into range.
  function automatic logic beyond_mem(input InstAddrBus pc, input int unsigned mem_bytes);
    logic [32:0] last_byte;
    last_byte = {1'b0, pc} + 33'd3;
    return last_byte >= {1'b0, mem_bytes};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if
//   Bundle of every signal the fetch unit exchanges with instruction memory,
//   the decode stage and the branch unit.
//   Memory side : inst_addr_o (read address), inst_i (combinational read data)
//   Redirect    : redirect_i, redirect_pc_i
//   Decode side : if_valid_o, if_inst_o, if_pc_o, if_ready_i
//   Status      : misalign_o (one-cycle pulse), oob_o (sticky)
//   modport master is the fetch unit, modport slave is its surroundings.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  InstAddrBus inst_addr_o;
  InstBus     inst_i;
  logic       redirect_i;
  InstAddrBus redirect_pc_i;
  logic       if_valid_o;
  InstBus     if_inst_o;
  InstAddrBus if_pc_o;
  logic       if_ready_i;
  logic       misalign_o;
  logic       oob_o;

  modport master (
    output inst_addr_o, if_valid_o, if_inst_o, if_pc_o, misalign_o, oob_o,
    input  inst_i, redirect_i, redirect_pc_i, if_ready_i
  );

  modport slave (
    input  inst_addr_o, if_valid_o, if_inst_o, if_pc_o, misalign_o, oob_o,
    output inst_i, redirect_i, redirect_pc_i, if_ready_i
  );

endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// fetch_queue
//   Small synchronous FIFO holding fetched {instruction, pc} entries.
//   clk, rst   : clock and asynchronous active-high reset
//   flush      : drop every entry and rewind the pointers (wins over push/pop)
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   head_data  : current head entry (stale contents when count is zero)
//   count      : number of valid entries, 0..DEPTH
//   The owner must not push into a full queue unless it also pops.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two so the
  // pointers wrap on their own; a flush simply rewinds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; an entry is only ever read after it has
  // been written. When full with a pop, the slot being overwritten is the
  // one leaving, which was already read out this cycle.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction fetch unit. Presents the PC to instruction memory, captures
//   the combinationally returned word into a fetch queue and hands the head
//   to decode over valid/ready. Redirects flush the queue and restart fetch.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : inst_fetch_if.master, memory/decode/redirect/status signals
//   RESET_PC, QDEPTH (power of 2, >= 2), MEM_BYTES (fetch halts beyond it)
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter InstAddrBus  RESET_PC  = DEFAULT_RESET_PC,
  parameter int          QDEPTH    = 2,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.master bus
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

  InstAddrBus       pc;
  logic             oob;
  logic             misalign;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             head_valid;
  logic             deq;
  logic             enq;
  logic             pc_oob;
  logic             has_room;

  // Head validity comes only from the registered count, so decode's ready
  // never reaches if_valid_o combinationally. A full queue can still take a
  // new word in the same cycle decode retires the head.
  assign head_valid = (count != '0);
  assign deq        = head_valid & bus.if_ready_i;
  assign pc_oob     = beyond_mem(pc, MEM_BYTES);
  assign has_room   = (count != QFULL) | deq;
  assign enq        = !bus.redirect_i & !oob & !pc_oob & has_room;

  assign push_entry.inst = bus.inst_i;
  assign push_entry.pc   = pc;

  fetch_queue #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_i),
    .push      (enq),
    .push_data (push_entry),
    .pop       (deq & !bus.redirect_i),
    .head_data (head),
    .count     (count)
  );

  // PC and status flags. A redirect wins over everything: it word-aligns the
  // target, clears the sticky out-of-bounds flag and reports a misaligned
  // target for exactly one cycle. Otherwise the PC steps by 4 on every
  // enqueue, and reaching the end of memory latches oob until the next
  // redirect or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      oob      <= 1'b0;
      misalign <= 1'b0;
    end else if (bus.redirect_i) begin
      pc       <= {bus.redirect_pc_i[31:2], 2'b00};
      oob      <= 1'b0;
      misalign <= (bus.redirect_pc_i[1:0] != 2'b00);
    end else begin
      misalign <= 1'b0;
      if (enq) begin
        pc <= pc + 32'd4;
      end
      if (pc_oob) begin
        oob <= 1'b1;
      end
    end
  end

  assign bus.inst_addr_o = pc;
  assign bus.if_valid_o  = head_valid;
  assign bus.if_inst_o   = head.inst;
  assign bus.if_pc_o     = head.pc;
  assign bus.misalign_o  = misalign;
  assign bus.oob_o       = oob;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A behavioural model (queue of
//   {inst, pc} entries, model PC and flags) is stepped on every clock edge
//   from the same inputs the DUT sees; a compare process checks all outputs
//   against it on every falling edge. Directed scenarios pin the model with
//   hand-computed literals, then a randomized phase exercises ready,
//   redirects (aligned, misaligned, out of range) and mid-stream resets.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int          QDEPTH    = 2;
  localparam int unsigned MEM_BYTES = 128;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_if bus();

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .QDEPTH    (QDEPTH),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic cmp_en   = 1'b0;

  ent_t        mq[$];
  logic [31:0] mpc  = 32'h0;
  logic        moob = 1'b0;
  logic        mmis = 1'b0;

  // Instruction memory: 32 words, anything outside reads back as a NOP.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [4:0] idx;
    idx = a[6:2];
    if (a < 32'(MEM_BYTES)) begin
      return mem[idx];
    end
    return NOP_INST;
  endfunction

  assign bus.inst_i = mem_read(bus.inst_addr_o);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and return just after the edge that uses them.
  task automatic applyStimulus(input logic rdy, input logic rdr, input logic [31:0] tgt);
    bus.if_ready_i    = rdy;
    bus.redirect_i    = rdr;
    bus.redirect_pc_i = tgt;
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.if_ready_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Behavioural model: decode takes the head if there is one and it is
  // ready; then a new word is fetched if memory still has a full word at the
  // PC and the queue has room left. Redirects and reset wipe the queue.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mpc  = 32'h0;
        moob = 1'b0;
        mmis = 1'b0;
      end else if (bus.redirect_i) begin
        mq.delete();
        mpc  = bus.redirect_pc_i & ~32'd3;
        moob = 1'b0;
        mmis = (bus.redirect_pc_i % 4) != 0;
      end else begin
        mmis = 1'b0;
        if (mq.size() > 0 && bus.if_ready_i) begin
          void'(mq.pop_front());
        end
        if (longint'(mpc) + 3 >= longint'(MEM_BYTES)) begin
          moob = 1'b1;
        end else if (!moob && mq.size() < QDEPTH) begin
          e.inst = mem_read(mpc);
          e.pc   = mpc;
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("inst_addr", bus.inst_addr_o, mpc);
      checkOutput("if_valid", 32'(bus.if_valid_o), 32'(mq.size() != 0));
      checkOutput("oob", 32'(bus.oob_o), 32'(moob));
      checkOutput("misalign", 32'(bus.misalign_o), 32'(mmis));
      if (mq.size() != 0) begin
        checkOutput("if_pc", bus.if_pc_o, mq[0].pc);
        checkOutput("if_inst", bus.if_inst_o, mq[0].inst);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] last_pc;
    logic [31:0] tgt;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
    end
    mem[1] = 32'h0020_81B3;

    doReset();
    cmp_en = 1'b1;

    $display("[TB] reset values and streaming fetch");
    checkOutput("rst_inst_addr", bus.inst_addr_o, 32'h0);
    checkOutput("rst_valid", 32'(bus.if_valid_o), 32'h0);
    checkOutput("rst_oob", 32'(bus.oob_o), 32'h0);
    checkOutput("rst_misalign", 32'(bus.misalign_o), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stream_pc0", bus.if_pc_o, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stream_pc4", bus.if_pc_o, 32'h4);
    checkOutput("stream_inst4", bus.if_inst_o, 32'h0020_81B3);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("stream_pc8", bus.if_pc_o, 32'h8);

    $display("[TB] backpressure");
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("bp_addr", bus.inst_addr_o, 32'h8);
    checkOutput("bp_head", bus.if_pc_o, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("bp_rel1", bus.if_pc_o, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("bp_rel2", bus.if_pc_o, 32'h8);

    $display("[TB] redirect while full");
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h38);
    checkOutput("rd_valid_n1", 32'(bus.if_valid_o), 32'h0);
    checkOutput("rd_addr_n1", bus.inst_addr_o, 32'h38);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("rd_pc_n2", bus.if_pc_o, 32'h38);
    checkOutput("rd_inst_n2", bus.if_inst_o, mem[14]);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 32'h41);
    checkOutput("mis_pulse", 32'(bus.misalign_o), 32'h1);
    checkOutput("mis_addr", bus.inst_addr_o, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mis_clear", 32'(bus.misalign_o), 32'h0);
    checkOutput("mis_pc", bus.if_pc_o, 32'h40);

    $display("[TB] run to end of memory");
    applyStimulus(1'b1, 1'b1, 32'h60);
    last_pc = 32'hDEAD_BEEF;
    repeat (12) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (bus.if_valid_o) begin
        last_pc = bus.if_pc_o;
      end
    end
    checkOutput("oob_last_pc", last_pc, 32'h7C);
    checkOutput("oob_flag", 32'(bus.oob_o), 32'h1);
    checkOutput("oob_addr", bus.inst_addr_o, 32'h80);
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("oob_cleared", 32'(bus.oob_o), 32'h0);
    checkOutput("oob_restart", bus.inst_addr_o, 32'h0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("mid_valid_before", 32'(bus.if_valid_o), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_valid_rst", 32'(bus.if_valid_o), 32'h0);
    checkOutput("mid_addr_rst", bus.inst_addr_o, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mid_first_pc", bus.if_pc_o, 32'h0);

    $display("[TB] randomized phase");
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end else begin
        tgt = 32'($urandom_range(0, 170));
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
      rst = 1'b0;
    end

    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
